// File: rtl/fifo_spike_reader.sv
// Read-side drain of the spike FIFO: pops one packet per POP/LATCH/SEND pass, splits it into cluster/neuron, counts deliveries.
// First spike_valid two edges after the start edge; SEND holds its fields indefinitely while spike_ready is low.
module fifo_spike_reader #(
  parameter int DATA_WIDTH      = 12,
  parameter int NEURON_ID_WIDTH = 8,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                                  rd_clk,
  input  logic                                  rst_n,
  input  logic                                  fifo_empty,
  input  logic [DATA_WIDTH-1:0]                 fifo_rd_data,
  output logic                                  fifo_rd_en,
  input  logic                                  step_start,
  output logic                                  spike_valid,
  input  logic                                  spike_ready,
  output logic [DATA_WIDTH-NEURON_ID_WIDTH-1:0] spike_cluster,
  output logic [NEURON_ID_WIDTH-1:0]            spike_neuron,
  output logic [COUNT_WIDTH-1:0]                spike_count,
  output logic                                  step_done,
  output logic                                  busy
);

  typedef enum logic [2:0] {IDLE, POP, LATCH, SEND, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    fifo_rd_en  = 1'b0;
    spike_valid = 1'b0;
    step_done   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (step_start) state_nxt = fifo_empty ? DONE : POP;
      end
      POP: begin
        fifo_rd_en = 1'b1;
        state_nxt  = LATCH;
      end
      LATCH: state_nxt = SEND;
      SEND: begin
        spike_valid = 1'b1;
        // The empty flag is only consulted here and in IDLE; late writes wait for the next step.
        if (spike_ready) state_nxt = fifo_empty ? DONE : POP;
      end
      DONE: begin
        step_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cluster <= '0;
      spike_neuron  <= '0;
      spike_count   <= '0;
    end else begin
      if (state == LATCH) begin
        spike_cluster <= fifo_rd_data[DATA_WIDTH-1:NEURON_ID_WIDTH];
        spike_neuron  <= fifo_rd_data[NEURON_ID_WIDTH-1:0];
      end
      if (state == IDLE && step_start) begin
        spike_count <= '0;
      end else if (state == SEND && spike_ready && spike_count != COUNT_MAX) begin
        spike_count <= spike_count + COUNT_ONE;
      end
    end
  end

endmodule
